// File: rtl/trace_pkg.sv
// trace_pkg: record layout and kind codes shared by the trace monitor and its FIFO.
package trace_pkg;
  localparam logic [1:0] KIND_REG  = 2'b01;
  localparam logic [1:0] KIND_MEM  = 2'b10;
  localparam logic [1:0] KIND_BOTH = 2'b11;
  localparam int REC_W     = 2 + 32 + 32 + 32 + 32;
  localparam int OFF_CYCLE = 0;
  localparam int OFF_DATA  = 32;
  localparam int OFF_ADDR  = 64;
  localparam int OFF_PC    = 96;
  localparam int OFF_KIND  = 128;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cycle;
  } trace_rec_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO; a push when full is only accepted alongside a pop.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 130
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_wdata;
endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: turns retiring register writes and stores into buffered, cycle-stamped trace records.
module cpu_trace_monitor
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic [31:0]            pc,
  input  logic                   pcwre,
  input  logic                   regwre,
  input  logic [4:0]             writereg,
  input  logic [31:0]            writedata,
  input  logic                   mwr,
  input  logic [31:0]            aluresult,
  input  logic [31:0]            readdata2,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [1:0]             trc_kind,
  output logic [31:0]            trc_pc,
  output logic [31:0]            trc_addr,
  output logic [31:0]            trc_data,
  output logic [31:0]            trc_cycle,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);
  logic              w_ev_reg;
  logic              w_ev_mem;
  logic              w_event;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  trace_rec_t        w_rec;
  trace_rec_t        w_head;
  logic [31:0]       r_cycle;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop;
  assign w_ev_reg = regwre & (writereg != 5'd0);
  assign w_ev_mem = mwr;
  assign w_event  = trace_en & pcwre & (w_ev_reg | w_ev_mem);
  // a full FIFO is never empty, so trc_ready alone tells whether a slot frees up
  assign w_drop   = w_event & w_full & ~trc_ready;
  always_comb begin
    w_rec.kind  = {w_ev_mem, w_ev_reg};
    w_rec.pc    = pc;
    w_rec.addr  = w_rec.kind == KIND_REG ? {27'd0, writereg} : aluresult;
    w_rec.data  = w_rec.kind == KIND_REG ? writedata : readdata2;
    w_rec.cycle = r_cycle;
  end
  trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_event),
    .i_pop   (trc_ready),
    .i_wdata (w_rec),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cycle    <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_drop && r_drop != {DROP_W{1'b1}}) r_drop <= r_drop + DROP_W'(1);
    end
  assign trc_valid = ~w_empty;
  assign trc_kind  = w_head.kind;
  assign trc_pc    = w_head.pc;
  assign trc_addr  = w_head.addr;
  assign trc_data  = w_head.data;
  assign trc_cycle = w_head.cycle;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed and randomized checks against a queue-based trace model.
module tb_cpu_trace_monitor;
  localparam int DEPTH = 16;
  logic        clk = 0;
  logic        reset = 0;
  logic        trace_en = 0;
  logic        pcwre = 0;
  logic        regwre = 0;
  logic        mwr = 0;
  logic        trc_ready = 0;
  logic [4:0]  writereg = 0;
  logic [31:0] pc = 0;
  logic [31:0] writedata = 0;
  logic [31:0] aluresult = 0;
  logic [31:0] readdata2 = 0;
  logic        trc_valid;
  logic [1:0]  trc_kind;
  logic [31:0] trc_pc;
  logic [31:0] trc_addr;
  logic [31:0] trc_data;
  logic [31:0] trc_cycle;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  cpu_trace_monitor #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .pc(pc), .pcwre(pcwre),
    .regwre(regwre), .writereg(writereg), .writedata(writedata), .mwr(mwr),
    .aluresult(aluresult), .readdata2(readdata2), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .trc_kind(trc_kind), .trc_pc(trc_pc),
    .trc_addr(trc_addr), .trc_data(trc_data), .trc_cycle(trc_cycle),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  k;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } rec_t;
  rec_t        q[$];
  int          m_drop = 0;
  bit          m_ovf = 0;
  logic [31:0] m_cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_on = 0;
  logic [129:0] h;
  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_drop = 0;
      m_ovf  = 0;
      m_cyc  = 0;
    end else begin : mdl
      bit   pop;
      bit   ev;
      bit   er;
      rec_t r;
      pop    = trc_ready && q.size() > 0;
      er     = regwre && writereg != 0;
      ev     = trace_en && pcwre && (er || mwr);
      r.k    = {mwr, er};
      r.pc   = pc;
      r.addr = mwr ? aluresult : {27'd0, writereg};
      r.data = mwr ? readdata2 : writedata;
      r.cyc  = m_cyc;
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) q.push_back(r);
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      m_cyc = m_cyc + 1;
    end
  end
  always @(negedge clk)
    if (chk_on && reset) begin
      check("valid", trc_valid, q.size() > 0);
      check("count", count, q.size());
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      if (q.size() > 0) begin
        check("head_kind", trc_kind, q[0].k);
        check("head_pc", trc_pc, q[0].pc);
        check("head_addr", trc_addr, q[0].addr);
        check("head_data", trc_data, q[0].data);
        check("head_cycle", trc_cycle, q[0].cyc);
      end
    end
  task automatic step(input bit en, input bit pw, input bit rw, input logic [4:0] wr,
                      input bit mw, input bit rdy);
    @(negedge clk);
    trace_en  = en;
    pcwre     = pw;
    regwre    = rw;
    writereg  = wr;
    mwr       = mw;
    trc_ready = rdy;
    pc        = $urandom;
    writedata = $urandom;
    aluresult = $urandom;
    readdata2 = $urandom;
  endtask
  task automatic idle(input bit rdy);
    step(0, 0, 0, 5'd0, 0, rdy);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset  = 1;
    chk_on = 1;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", trc_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    step(1, 1, 1, 5'd8, 0, 0);
    pc = 32'h4;
    writedata = 32'h5;
    idle(0);
    check("reg_valid", trc_valid, 1);
    check("reg_kind", trc_kind, 2'b01);
    check("reg_addr", trc_addr, 32'd8);
    check("reg_data", trc_data, 32'd5);
    check("reg_pc", trc_pc, 32'h4);
    h = {trc_kind, trc_pc, trc_addr, trc_data, trc_cycle};
    repeat (3) begin
      step(1, 1, 1, 5'd3, 0, 0);
      check("hold_fields", {trc_kind, trc_pc, trc_addr, trc_data, trc_cycle}, h);
    end
    repeat (6) idle(1);
    step(1, 1, 1, 5'd0, 0, 0);
    step(1, 0, 1, 5'd5, 1, 0);
    step(0, 1, 1, 5'd5, 1, 0);
    idle(0);
    check("filter_count", count, 0);
    step(1, 1, 0, 5'd3, 1, 0);
    aluresult = 32'h10;
    readdata2 = 32'hDEADBEEF;
    step(1, 1, 1, 5'd9, 1, 0);
    aluresult = 32'h20;
    readdata2 = 32'h1234;
    idle(0);
    check("store_kind", trc_kind, 2'b10);
    check("store_addr", trc_addr, 32'h10);
    check("store_data", trc_data, 32'hDEADBEEF);
    idle(1);
    idle(0);
    check("both_kind", trc_kind, 2'b11);
    check("both_addr", trc_addr, 32'h20);
    check("both_data", trc_data, 32'h1234);
    repeat (3) idle(1);
    repeat (20) step(1, 1, 1, 5'($urandom_range(1, 31)), 0, 0);
    idle(0);
    check("fill_count", count, 16);
    check("fill_overflow", overflow, 1);
    check("fill_drop", drop_cnt, 4);
    repeat (10) step(1, 1, 1'($urandom), 5'($urandom_range(1, 31)), 1, 1);
    idle(0);
    check("fullpop_count", count, 16);
    check("fullpop_drop", drop_cnt, 4);
    repeat (20) idle(1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'($urandom), 5'($urandom),
           1'($urandom), i < 1500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
    repeat (20) idle(1);
    repeat (5) step(1, 1, 1, 5'($urandom_range(1, 31)), 0, 0);
    idle(0);
    check("mid_count", count, 5);
    @(negedge clk);
    reset = 0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", trc_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_drop", drop_cnt, 0);
    @(negedge clk);
    reset = 1;
    step(1, 1, 1, 5'd7, 0, 0);
    idle(0);
    check("restart_cycle", trc_cycle, 32'd1);
    idle(1);
    idle(0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
